apb_reg_bank: RTL

//  Parametrised APB3 slave register bank: NUM_REGS read/write control registers plus one

---
 rtl/apb_reg_pkg.sv | 20 ++
 rtl/apb_slave_fsm.sv | 84 ++++++++
 rtl/apb_reg_bank.sv | 124 ++++++++++++
 3 files changed

// File: rtl/apb_reg_pkg.sv
// Shared definitions for the APB register bank: FSM state encoding,
// address-to-word-index mapping.
package apb_reg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } apb_state_e;

  // Byte address bits below this are ignored; registers are word-indexed.
  localparam int unsigned ADDR_LSB = 2;

  // Word index of a (zero-extended) byte address.
  function automatic logic [31:0] idx_of(input logic [31:0] paddr);
    return paddr >> ADDR_LSB;
  endfunction

endpackage

// File: rtl/apb_slave_fsm.sv
// APB3 slave handshake engine: tracks IDLE/SETUP/WAIT/DONE, inserts
// WAIT_STATES extra access cycles, latches the transfer attributes at
// setup, and produces the commit strobe and a registered PREADY pulse.
module apb_slave_fsm
  import apb_reg_pkg::*;
#(
  parameter int unsigned AW          = 20,
  parameter int unsigned DW          = 32,
  parameter int unsigned SW          = DW / 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-1:0] paddr,
  input  logic [DW-1:0] pwdata,
  input  logic [SW-1:0] pstrb,
  output logic          commit,
  output logic          pready,
  output logic          lat_write,
  output logic [AW-1:0] lat_addr,
  output logic [DW-1:0] lat_data,
  output logic [SW-1:0] lat_strb
);

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  apb_state_e state;
  logic [3:0] cnt;

  // Commit happens on the edge that leaves WAIT with the counter exhausted
  // and the master still selecting us; an aborted access never commits.
  always_comb begin
    commit = 1'b0;
    if (state == WAIT && psel && cnt == '0) commit = 1'b1;
  end

  // Transfer sequencing, wait-state counting and attribute latching.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pready    <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_strb  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            state     <= SETUP;
            cnt       <= WS_INIT;
            lat_write <= pwrite;
            lat_addr  <= paddr;
            lat_data  <= pwdata;
            lat_strb  <= pstrb;
          end
        end
        SETUP: begin
          state <= psel ? WAIT : IDLE;
        end
        WAIT: begin
          if (!psel) begin
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            pready <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          pready <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/apb_reg_bank.sv
// APB3 slave register bank: NUM_REGS read/write words plus a read-only
// status word at index NUM_REGS; accesses beyond that return PSLVERR.
// Optional byte-lane writes are enabled with the APB_REG_PSTRB_EN macro.
module apb_reg_bank
  import apb_reg_pkg::*;
#(
  parameter int unsigned AMBA_WORD       = 32,
  parameter int unsigned AMBA_ADDR_WIDTH = 20,
  parameter int unsigned NUM_REGS        = 4,
  parameter int unsigned WAIT_STATES     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AMBA_ADDR_WIDTH-1:0]    PADDR,
  input  logic [AMBA_WORD-1:0]          PWDATA,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  input  logic                          PWRITE,
`ifdef APB_REG_PSTRB_EN
  input  logic [AMBA_WORD/8-1:0]        PSTRB,
`endif
  output logic [AMBA_WORD-1:0]          PRDATA,
  output logic                          PREADY,
  output logic                          PSLVERR,
  output logic [NUM_REGS*AMBA_WORD-1:0] regs_flat,
  output logic [NUM_REGS-1:0]           reg_wr_pulse,
  input  logic [AMBA_WORD-1:0]          status_in
);

  localparam int unsigned SB = AMBA_WORD / 8;

  logic                       commit;
  logic                       lat_write;
  logic [AMBA_ADDR_WIDTH-1:0] lat_addr;
  logic [AMBA_WORD-1:0]       lat_data;
  logic [SB-1:0]              lat_strb;
  logic [SB-1:0]              strb_in;

  logic [AMBA_WORD-1:0] regs [NUM_REGS];
  logic [31:0]          idx;
  logic                 idx_rw;
  logic                 idx_status;
  logic [AMBA_WORD-1:0] rd_word;

`ifdef APB_REG_PSTRB_EN
  assign strb_in = PSTRB;
`else
  assign strb_in = '1;
`endif

  apb_slave_fsm #(
    .AW          (AMBA_ADDR_WIDTH),
    .DW          (AMBA_WORD),
    .SW          (SB),
    .WAIT_STATES (WAIT_STATES)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .psel      (PSEL),
    .penable   (PENABLE),
    .pwrite    (PWRITE),
    .paddr     (PADDR),
    .pwdata    (PWDATA),
    .pstrb     (strb_in),
    .commit    (commit),
    .pready    (PREADY),
    .lat_write (lat_write),
    .lat_addr  (lat_addr),
    .lat_data  (lat_data),
    .lat_strb  (lat_strb)
  );

  // Address decode and read-data selection for the latched access.
  always_comb begin
    idx        = idx_of(32'(lat_addr));
    idx_rw     = (idx < NUM_REGS);
    idx_status = (idx == NUM_REGS);
    rd_word    = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (idx == i) rd_word = regs[i];
    end
    if (idx_status) rd_word = status_in;
  end

  // Present the register array as one flat vector for the core.
  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_flat[i*AMBA_WORD +: AMBA_WORD] = regs[i];
    end
  end

  // Register updates, write pulses, read data and error flag, all taken
  // on the commit edge so they become visible together with PREADY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PRDATA       <= '0;
      PSLVERR      <= 1'b0;
      reg_wr_pulse <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (commit) begin
        if (lat_write) begin
          PSLVERR <= !idx_rw;
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (idx_rw && idx == i) begin
              reg_wr_pulse[i] <= 1'b1;
              for (int unsigned b = 0; b < SB; b++) begin
                if (lat_strb[b]) regs[i][b*8 +: 8] <= lat_data[b*8 +: 8];
              end
            end
          end
        end else begin
          PSLVERR <= !(idx_rw || idx_status);
          PRDATA  <= rd_word;
        end
      end else if (PREADY) begin
        PSLVERR <= 1'b0;
      end
    end
  end

endmodule
